xor_perm_cipher: RTL

Parametrised, streaming, bidirectional byte cipher. Each beat is `LANES` bytes wide; every byte is XORed with a rotating per-lane key and bit-rotated. Direction (encrypt/decrypt) is selectable per beat. A two-stage valid/ready pipeline with full backpressure replaces the fixed `en`/`v` strobe of the previous encrypt/decrypt units, so one instance covers both directions in the link datapath.

---
 rtl/xor_perm_cipher_if.sv | 27 ++
 rtl/xor_perm_cipher.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/xor_perm_cipher_if.sv
// Streaming beat bus for xor_perm_cipher.
//   master : upstream/downstream side (drives in_*, din, mode, out_ready)
//   slave  : the cipher block (drives in_ready, out_valid, dout, out_last)
// LANES sets the beat width in bytes; din/dout lane i = [8i+7:8i].
interface xor_perm_cipher_if #(
  parameter int LANES = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   din;
  logic                 mode;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   dout;
  logic                 out_last;

  modport master (
    output in_valid, din, mode, in_last, out_ready,
    input  in_ready, out_valid, dout, out_last
  );

  modport slave (
    input  in_valid, din, mode, in_last, out_ready,
    output in_ready, out_valid, dout, out_last
  );
endinterface

// File: rtl/xor_perm_cipher.sv
// xor_perm_cipher: streaming bidirectional byte cipher, LANES bytes per beat.
// Each byte is combined with key[(kp+lane) mod NUM_KEYS]:
//   encrypt: rotl3(x ^ k)      decrypt: rotr3(x) ^ k
// Two-stage valid/ready pipeline (S1 = operands + resolved keys, S2 = result),
// capacity 2 beats, 1 beat/cycle with no bubbles.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   bus (slave modport) : in_valid/in_ready/din/mode/in_last,
//                         out_valid/out_ready/dout/out_last
//   key_wr/key_idx/key_data : runtime key ring write, present only when
//                         CIPHER_KEY_CFG_EN is defined; otherwise the ring is
//                         the constant KEY_INIT.
module xor_perm_cipher #(
  parameter int                    LANES    = 2,
  parameter int                    NUM_KEYS = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_INIT = {8'h3C, 8'h5A, 8'h96}
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef CIPHER_KEY_CFG_EN
  input  logic                        key_wr,
  input  logic [$clog2(NUM_KEYS)-1:0] key_idx,
  input  logic [7:0]                  key_data,
`endif
  xor_perm_cipher_if.slave            bus
);
  localparam int KW = $clog2(NUM_KEYS);

  typedef logic [NUM_KEYS-1:0][7:0] ring_t;
  typedef logic [LANES-1:0][7:0]    beat_t;

  ring_t ring;

`ifdef CIPHER_KEY_CFG_EN
  ring_t ring_q, ring_d;

  always_comb begin
    ring_d = ring_q;
    // Out-of-range indices are dropped silently.
    if (key_wr && (32'(key_idx) < NUM_KEYS)) ring_d[key_idx] = key_data;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) ring_q <= KEY_INIT;
    else      ring_q <= ring_d;

  assign ring = ring_q;
`else
  assign ring = KEY_INIT;
`endif

  logic          s1_vld_q, s1_vld_d;
  logic          s1_mode_q, s1_mode_d;
  logic          s1_last_q, s1_last_d;
  beat_t         s1_dat_q, s1_dat_d;
  beat_t         s1_key_q, s1_key_d;
  logic          s2_vld_q, s2_vld_d;
  logic          s2_last_q, s2_last_d;
  beat_t         s2_dat_q, s2_dat_d;
  logic [KW-1:0] kp_q, kp_d;

  beat_t lane_key;
  beat_t xf;
  logic  adv, in_rdy, acc;

  // Per-lane key select and transform. Keys are captured into S1 so a
  // ring write in the accept cycle only affects later beats.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] t;
    assign lane_key[i] = ring[KW'((32'(kp_q) + i) % NUM_KEYS)];
    assign t           = s1_dat_q[i] ^ s1_key_q[i];
    assign xf[i]       = s1_mode_q ? ({s1_dat_q[i][2:0], s1_dat_q[i][7:3]} ^ s1_key_q[i])
                                   : {t[4:0], t[7:5]};
  end

  always_comb begin
    adv    = !s2_vld_q || bus.out_ready;
    in_rdy = !s1_vld_q || adv;
    acc    = bus.in_valid && in_rdy;

    s1_vld_d  = s1_vld_q;
    s1_mode_d = s1_mode_q;
    s1_last_d = s1_last_q;
    s1_dat_d  = s1_dat_q;
    s1_key_d  = s1_key_q;
    s2_vld_d  = s2_vld_q;
    s2_last_d = s2_last_q;
    s2_dat_d  = s2_dat_q;
    kp_d      = kp_q;

    if (acc) begin
      s1_vld_d  = 1'b1;
      s1_mode_d = bus.mode;
      s1_last_d = bus.in_last;
      s1_dat_d  = bus.din;
      s1_key_d  = lane_key;
      // A frame boundary restarts the key sequence.
      kp_d      = bus.in_last ? '0 : KW'((32'(kp_q) + LANES) % NUM_KEYS);
    end else if (adv) begin
      s1_vld_d  = 1'b0;
    end

    if (adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d  = xf;
        s2_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_dat_q  <= '0;
      s1_key_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_dat_q  <= '0;
      kp_q      <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_mode_q <= s1_mode_d;
      s1_last_q <= s1_last_d;
      s1_dat_q  <= s1_dat_d;
      s1_key_q  <= s1_key_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      s2_dat_q  <= s2_dat_d;
      kp_q      <= kp_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_vld_q;
  assign bus.dout      = s2_dat_q;
  assign bus.out_last  = s2_last_q;
endmodule
